memory_bus_arbiter: RTL and testbench
=====================================

// Module: memory_bus_arbiter
// PURPOSE
//  Shares the single MemoryBus port between instruction fetch (requester 0) and load/store (requester 1).
//  Round-robin arbitration; exactly one transaction outstanding on the bus.
//  Each response is routed back to the requester that issued the request, matched by id.
//  Sits between FetchStage/LoadStoreStage and the memory model/cache.
// PARAMETERS
//  ADDR_W        64    memory_address_t width
//  DATA_W        64    bus payload width (one fetched_instruction_data_t)
//  ID_W          2     memory_bus_id width; fetch id = FETCH_ID, lsu id = LSU_ID
//  FETCH_ID      1     bus id stamped on fetch requests
//  LSU_ID        2     bus id stamped on load/store requests
//  TIMEOUT       1023  max cycles waiting for a response before forced completion
// PORTS
//  clk             in   1       clock
//  reset           in   1       asynchronous, active-high reset
//  fetch_req_valid in   1       fetch read request (held until fetch_req_ready)
//  fetch_req_addr  in   ADDR_W  fetch address (low 3 bits dropped on issue)
//  fetch_req_ready out  1       1-cycle pulse: request captured
//  fetch_rsp_valid out  1       1-cycle pulse: fetch_rsp_data valid
//  fetch_rsp_data  out  DATA_W  read payload
//  lsu_req_valid   in   1       load/store request (held until lsu_req_ready)
//  lsu_req_write   in   1       1 = write, 0 = read
//  lsu_req_addr    in   ADDR_W  address (low 3 bits dropped on issue)
//  lsu_req_data    in   DATA_W  write data
//  lsu_req_ready   out  1       1-cycle pulse: request captured
//  lsu_rsp_valid   out  1       1-cycle pulse: read data / write ack
//  lsu_rsp_data    out  DATA_W  read payload (0 for write ack)
//  mem_req_valid   out  1       bus request valid
//  mem_req_write   out  1       bus request type
//  mem_req_addr    out  ADDR_W  8-byte-aligned address
//  mem_req_data    out  DATA_W  write data
//  mem_req_id      out  ID_W    requester id
//  mem_req_ready   in   1       bus accepts the request this cycle
//  mem_rsp_valid   in   1       bus response valid (read_response or write_ack)
//  mem_rsp_id      in   ID_W    response id
//  mem_rsp_data    in   DATA_W  response payload
//  err_id          out  1       sticky: response id did not match the outstanding id
//  err_timeout     out  1       sticky: TIMEOUT expired
// BEHAVIOUR
//  - Reset: every output is 0; state = IDLE; last_grant = 1 (fetch wins the first tie); timer = 0.
//  - IDLE: if either request is valid, grant it. On a tie, grant the requester that is not last_grant.
//    In that cycle: pulse the winner's req_ready, latch {write, addr & ~7, data, id}, update last_grant,
//    and go to ISSUE. Fetch requests are always reads with data 0.
//  - ISSUE: mem_req_valid = 1 with the latched fields, held stable.
//    When mem_req_ready = 1, drop mem_req_valid the next cycle and go to WAIT with timer = 0.
//  - WAIT: timer increments each cycle. On mem_rsp_valid with mem_rsp_id == latched id:
//    next cycle, pulse the owning rsp_valid with the registered data (data forced to 0 for a write),
//    then go to IDLE.
//    A response with a wrong id is dropped and sets err_id; the arbiter keeps waiting.
//    When timer == TIMEOUT: set err_timeout, pulse the owner's rsp_valid with data 0, go to IDLE.
//  - Minimum latency from req_ready to rsp_valid: 3 cycles (ISSUE 1, WAIT 1, respond 1), with ready and response immediate.
//  - A new grant can occur in the cycle of the rsp_valid pulse. req_ready is never asserted outside IDLE.
//  - mem_rsp_valid in IDLE or ISSUE: ignored and sets err_id.
//  - A requester dropping valid before ready is a protocol violation; its behaviour is undefined.
//  - Reset mid-transaction: abort immediately, clear all state, no response is delivered.
//    Sticky errors clear only on reset.
//  - timer is a saturating clog2(TIMEOUT+1)-bit counter.
// TESTING
//  1. Fetch only, addr 0x1003, bus ready and responding at once, id 1, data 0xAB
//     -> mem_req_addr 0x1000, id 1; fetch_rsp_data 0xAB 3 cycles after fetch_req_ready.
//  2. Fetch and lsu both valid, continuously, from reset -> grants alternate fetch, lsu, fetch, lsu;
//     no requester is granted twice in a row.
//  3. lsu write addr 0x20, data 0x55, mem_req_ready held low 4 cycles
//     -> mem_req fields stable for all 5 cycles; lsu_rsp_valid with data 0 after the ack.
//  4. Outstanding id 2, bus returns id 1, then id 2 -> err_id = 1; the id-1 response is dropped;
//     lsu_rsp_valid fires only for id 2.
//  5. TIMEOUT = 8, no response -> err_timeout = 1 and owner rsp_valid with data 0 after 8 WAIT cycles;
//     the next request is then granted.
//  6. reset pulsed while in WAIT -> all outputs 0 asynchronously; the late response is ignored
//     apart from setting err_id.

Source files
------------

// File: rtl/memory_bus_arbiter.sv
// rtl/memory_bus_arbiter.sv - round-robin sharing of one memory bus between fetch and load/store
module memory_bus_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int ID_W     = 2,
    parameter int FETCH_ID = 1,
    parameter int LSU_ID   = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req_valid,
    input  logic [ADDR_W-1:0] fetch_req_addr,
    output logic              fetch_req_ready,
    output logic              fetch_rsp_valid,
    output logic [DATA_W-1:0] fetch_rsp_data,
    input  logic              lsu_req_valid,
    input  logic              lsu_req_write,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic [DATA_W-1:0] lsu_req_data,
    output logic              lsu_req_ready,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rsp_data,
    output logic              mem_req_valid,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    output logic [ID_W-1:0]   mem_req_id,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [ID_W-1:0]   mem_rsp_id,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              err_id,
    output logic              err_timeout
);

    localparam int                TMR_W      = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]  TMR_LIM    = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_SAT    = {TMR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(7);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              last_grant;   // 1 = load/store was granted last
    logic              lat_owner;    // 1 = outstanding transaction belongs to load/store
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [ID_W-1:0]   lat_id;
    logic [TMR_W-1:0]  timer;

    logic grant_fetch;
    logic grant_lsu;
    logic rsp_match;
    logic rsp_timeout;
    logic done;

    // Fetch wins unless load/store is also asking and fetch was granted last.
    assign grant_fetch = fetch_req_valid & (~lsu_req_valid | last_grant);
    assign grant_lsu   = lsu_req_valid & ~grant_fetch;
    assign rsp_match   = mem_rsp_valid && (mem_rsp_id == lat_id);
    assign rsp_timeout = (timer == TMR_LIM);
    assign done        = (state == S_WAIT) && (rsp_match || rsp_timeout);

    assign mem_req_write = lat_write;
    assign mem_req_addr  = lat_addr;
    assign mem_req_data  = lat_data;
    assign mem_req_id    = lat_id;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one transaction at a time, IDLE -> ISSUE -> WAIT -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fetch_req_valid || lsu_req_valid) state_nxt = S_ISSUE;
            S_ISSUE: if (mem_req_ready) state_nxt = S_WAIT;
            S_WAIT:  if (done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs: grant pulses only in IDLE and never while reset is held.
    always_comb begin
        mem_req_valid   = 1'b0;
        fetch_req_ready = 1'b0;
        lsu_req_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                fetch_req_ready = grant_fetch & ~reset;
                lsu_req_ready   = grant_lsu & ~reset;
            end
            S_ISSUE: mem_req_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: request latch, response timer, response pulses and sticky errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant      <= 1'b1;
            lat_owner       <= 1'b0;
            lat_write       <= 1'b0;
            lat_addr        <= '0;
            lat_data        <= '0;
            lat_id          <= '0;
            timer           <= '0;
            fetch_rsp_valid <= 1'b0;
            fetch_rsp_data  <= '0;
            lsu_rsp_valid   <= 1'b0;
            lsu_rsp_data    <= '0;
            err_id          <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            if (state == S_IDLE && (grant_fetch || grant_lsu)) begin
                last_grant <= grant_lsu;
                lat_owner  <= grant_lsu;
                if (grant_lsu) begin
                    lat_write <= lsu_req_write;
                    lat_addr  <= lsu_req_addr & ALIGN_MASK;
                    lat_data  <= lsu_req_data;
                    lat_id    <= ID_W'(LSU_ID);
                end else begin
                    lat_write <= 1'b0;
                    lat_addr  <= fetch_req_addr & ALIGN_MASK;
                    lat_data  <= '0;
                    lat_id    <= ID_W'(FETCH_ID);
                end
            end

            if (state == S_ISSUE) begin
                timer <= '0;
            end else if (state == S_WAIT && timer != TMR_SAT) begin
                timer <= timer + TMR_W'(1);
            end

            fetch_rsp_valid <= done & ~lat_owner;
            lsu_rsp_valid   <= done & lat_owner;
            // A matched response takes priority over a timeout in the same cycle.
            fetch_rsp_data  <= (done && !lat_owner && rsp_match && !lat_write) ? mem_rsp_data : '0;
            lsu_rsp_data    <= (done && lat_owner && rsp_match && !lat_write) ? mem_rsp_data : '0;

            if (mem_rsp_valid && (state != S_WAIT || mem_rsp_id != lat_id)) begin
                err_id <= 1'b1;
            end
            if (state == S_WAIT && !rsp_match && rsp_timeout) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb/tb_memory_bus_arbiter.sv - directed self-checking bench for memory_bus_arbiter
module tb_memory_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        fetch_req_valid;
    logic [63:0] fetch_req_addr;
    logic        fetch_req_ready;
    logic        fetch_rsp_valid;
    logic [63:0] fetch_rsp_data;
    logic        lsu_req_valid;
    logic        lsu_req_write;
    logic [63:0] lsu_req_addr;
    logic [63:0] lsu_req_data;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;
    logic [63:0] lsu_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_write;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_data;
    logic [1:0]  mem_req_id;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [1:0]  mem_rsp_id;
    logic [63:0] mem_rsp_data;
    logic        err_id;
    logic        err_timeout;

    int checks;
    int failures;

    memory_bus_arbiter #(
        .ADDR_W(64), .DATA_W(64), .ID_W(2), .FETCH_ID(1), .LSU_ID(2), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .fetch_req_valid(fetch_req_valid), .fetch_req_addr(fetch_req_addr),
        .fetch_req_ready(fetch_req_ready), .fetch_rsp_valid(fetch_rsp_valid),
        .fetch_rsp_data(fetch_rsp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_write(lsu_req_write),
        .lsu_req_addr(lsu_req_addr), .lsu_req_data(lsu_req_data),
        .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rsp_data(lsu_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_id(mem_req_id), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_id(mem_rsp_id),
        .mem_rsp_data(mem_rsp_data),
        .err_id(err_id), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Move to the input-drive point of the next cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int   g;
        logic exp_lsu;
        logic last_lsu;
        logic resp;
        logic [1:0] rid;
        int   rsp_n;
        int   lsu_n;

        checks = 0;
        failures = 0;
        reset = 1'b1;
        fetch_req_valid = 1'b1;
        fetch_req_addr  = 64'h1003;
        lsu_req_valid   = 1'b1;
        lsu_req_write   = 1'b0;
        lsu_req_addr    = 64'h0;
        lsu_req_data    = 64'h0;
        mem_req_ready   = 1'b0;
        mem_rsp_valid   = 1'b0;
        mem_rsp_id      = 2'd0;
        mem_rsp_data    = 64'h0;

        // Reset state, with both requesters asking.
        @(negedge clk);
        check("rst_fetch_ready", fetch_req_ready, 0);
        check("rst_lsu_ready", lsu_req_ready, 0);
        check("rst_mem_valid", mem_req_valid, 0);
        check("rst_mem_addr", mem_req_addr, 0);
        check("rst_mem_id", mem_req_id, 0);
        check("rst_rsp_valid", {fetch_rsp_valid, lsu_rsp_valid}, 0);
        check("rst_err", {err_id, err_timeout}, 0);

        // Test 1: fetch alone, immediate bus.
        step();
        reset = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("t1_fetch_ready", fetch_req_ready, 1);
        check("t1_lsu_ready", lsu_req_ready, 0);
        step();
        fetch_req_valid = 1'b0;
        @(negedge clk);
        check("t1_mem_valid", mem_req_valid, 1);
        check("t1_mem_addr", mem_req_addr, 64'h1000);
        check("t1_mem_id", mem_req_id, 1);
        check("t1_mem_write", mem_req_write, 0);
        check("t1_mem_data", mem_req_data, 0);
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = 2'd1;
        mem_rsp_data  = 64'hAB;
        @(negedge clk);
        check("t1_rsp_early", fetch_rsp_valid, 0);
        step();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("t1_rsp_valid", fetch_rsp_valid, 1);
        check("t1_rsp_data", fetch_rsp_data, 64'hAB);
        check("t1_lsu_rsp", lsu_rsp_valid, 0);

        // Test 2: both requesting continuously from reset.
        step();
        reset = 1'b1;
        fetch_req_valid = 1'b1;
        fetch_req_addr  = 64'h2000;
        lsu_req_valid   = 1'b1;
        lsu_req_write   = 1'b0;
        lsu_req_addr    = 64'h208;
        step();
        reset = 1'b0;
        g = 0;
        exp_lsu = 1'b0;
        last_lsu = 1'b0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (fetch_req_ready || lsu_req_ready) begin
                check("t2_onehot", fetch_req_ready & lsu_req_ready, 0);
                check("t2_grant_lsu", lsu_req_ready, exp_lsu);
                last_lsu = lsu_req_ready;
                exp_lsu = ~exp_lsu;
                g++;
            end
            resp = mem_req_valid & mem_req_ready;
            rid  = mem_req_id;
            if (resp) check("t2_mem_id", mem_req_id, last_lsu ? 2 : 1);
            step();
            if (g == 4) begin
                fetch_req_valid = 1'b0;
                lsu_req_valid   = 1'b0;
            end
            mem_rsp_valid = resp;
            mem_rsp_id    = rid;
            mem_rsp_data  = 64'h100 + 64'(c);
        end
        check("t2_grant_count", g, 4);
        check("t2_err_id", err_id, 0);

        // Test 3: lsu write held off by the bus for 4 cycles.
        lsu_req_valid = 1'b1;
        lsu_req_write = 1'b1;
        lsu_req_addr  = 64'h20;
        lsu_req_data  = 64'h55;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("t3_lsu_ready", lsu_req_ready, 1);
        check("t3_fetch_ready", fetch_req_ready, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            lsu_req_valid = 1'b0;
            mem_req_ready = (k == 4);
            @(negedge clk);
            check("t3_mem_valid", mem_req_valid, 1);
            check("t3_mem_addr", mem_req_addr, 64'h20);
            check("t3_mem_data", mem_req_data, 64'h55);
            check("t3_mem_write", mem_req_write, 1);
            check("t3_mem_id", mem_req_id, 2);
        end
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = 2'd2;
        mem_rsp_data  = 64'hDEAD;
        @(negedge clk);
        check("t3_mem_drop", mem_req_valid, 0);
        check("t3_rsp_early", lsu_rsp_valid, 0);
        step();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("t3_rsp_valid", lsu_rsp_valid, 1);
        check("t3_rsp_data", lsu_rsp_data, 0);

        // Test 4: wrong id dropped, right id delivered.
        step();
        lsu_req_valid = 1'b1;
        lsu_req_write = 1'b0;
        lsu_req_addr  = 64'h40;
        lsu_req_data  = 64'h99;
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("t4_lsu_ready", lsu_req_ready, 1);
        step();
        lsu_req_valid = 1'b0;
        @(negedge clk);
        check("t4_mem_id", mem_req_id, 2);
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = 2'd1;
        mem_rsp_data  = 64'h11;
        @(negedge clk);
        check("t4_err_pre", err_id, 0);
        step();
        mem_rsp_id   = 2'd2;
        mem_rsp_data = 64'h22;
        @(negedge clk);
        check("t4_err_id", err_id, 1);
        check("t4_drop", {fetch_rsp_valid, lsu_rsp_valid}, 0);
        step();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("t4_rsp_valid", lsu_rsp_valid, 1);
        check("t4_rsp_data", lsu_rsp_data, 64'h22);
        check("t4_fetch_rsp", fetch_rsp_valid, 0);

        // Test 5: timeout on a fetch; a waiting lsu request is granted in the pulse cycle.
        step();
        fetch_req_valid = 1'b1;
        fetch_req_addr  = 64'h88;
        @(negedge clk);
        check("t5_fetch_ready", fetch_req_ready, 1);
        rsp_n = -1;
        lsu_n = -1;
        for (int n = 1; n < 20; n++) begin
            step();
            fetch_req_valid = 1'b0;
            if (n >= 2) begin
                lsu_req_valid = 1'b1;
                lsu_req_write = 1'b0;
                lsu_req_addr  = 64'h100;
            end
            @(negedge clk);
            if (lsu_req_ready && lsu_n < 0) lsu_n = n;
            if (fetch_rsp_valid) begin
                rsp_n = n;
                check("t5_rsp_data", fetch_rsp_data, 0);
                check("t5_err_timeout", err_timeout, 1);
                break;
            end
        end
        check("t5_rsp_cycle", rsp_n, 11);
        check("t5_next_grant_cycle", lsu_n, 11);

        // Test 6: reset during WAIT, then a late response.
        step();
        lsu_req_valid = 1'b0;
        @(negedge clk);
        check("t6_issue_id", {mem_req_valid, mem_req_id}, 3'b110);
        step();
        reset = 1'b1;
        lsu_req_valid = 1'b1;
        @(negedge clk);
        check("t6_rst_mem_valid", mem_req_valid, 0);
        check("t6_rst_ready", {fetch_req_ready, lsu_req_ready}, 0);
        check("t6_rst_err", {err_id, err_timeout}, 0);
        check("t6_rst_mem_fields", {mem_req_addr, mem_req_id}, 0);
        step();
        reset = 1'b0;
        lsu_req_valid = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = 2'd2;
        mem_rsp_data  = 64'h77;
        @(negedge clk);
        check("t6_no_rsp", lsu_rsp_valid, 0);
        step();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("t6_late_rsp", {fetch_rsp_valid, lsu_rsp_valid}, 0);
        check("t6_err_id", err_id, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
